// File: rtl/led_show_pkg.sv
// Shared types and constants for the LED/7-segment show sequencer:
// program states, segment glyphs and the speed-select decode.
package led_show_pkg;

    localparam int LEDR_W = 18;

    typedef enum logic [1:0] {
        FILL_L = 2'd0,
        FILL_R = 2'd1,
        BLINK  = 2'd2
    } state_t;

    // Active-low segment codes, bit 6 = segment g.
    localparam logic [6:0] GLYPH_H = 7'b0001001;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_P = 7'b0001100;
    localparam logic [6:0] GLYPH_Y = 7'b0010001;
    localparam logic [6:0] GLYPH_D = 7'b1000000;
    localparam logic [6:0] BLANK   = 7'b1111111;

    function automatic logic [3:0] speed_mult(input logic [1:0] sel);
        logic [3:0] m;
        case (sel)
            2'b00:   m = 4'd1;
            2'b01:   m = 4'd2;
            2'b10:   m = 4'd5;
            2'b11:   m = 4'd10;
            default: m = 4'd1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-enable generator: base-tick prescaler followed by a speed divider,
// both frozen while paused so release resumes from the held counts.
module led_tick_gen
    import led_show_pkg::*;
#(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pause,
    input  logic [1:0] speed,
    output logic       step_en
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;
    logic [3:0]    div_r;
    logic [3:0]    mult_s;
    logic          wrap_s;
    logic          div_hit_s;

    // Tick and divider compare; >= lets a lowered multiplier fire on the next tick.
    always_comb begin
        mult_s    = speed_mult(speed);
        wrap_s    = (cnt_r == CNT_LAST);
        div_hit_s = (div_r >= (mult_s - 4'd1));
        step_en   = wrap_s && div_hit_s && !pause;
    end

    // Prescaler and divider counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
            div_r <= 4'd0;
        end else if (pause) begin
            cnt_r <= cnt_r;
            div_r <= div_r;
        end else if (wrap_s) begin
            cnt_r <= {CW{1'b0}};
            div_r <= div_hit_s ? 4'd0 : (div_r + 4'd1);
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            div_r <= div_r;
        end
    end

endmodule

// File: rtl/led_show_sched.sv
// Top of the LED show: switch synchronizer, program FSM with step counter,
// and registered LED/HEX decode.
module led_show_sched
    import led_show_pkg::*;
#(
    parameter int TICK_DIV   = 10_000_000,
    parameter int BLINK_REPS = 4
) (
    input  logic              CLOCK_50,
    input  logic              KEY0,
    input  logic [2:0]        SW,
    output logic [LEDR_W-1:0] LEDR,
    output logic [7:0]        LEDG,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5,
    output logic [6:0]        HEX6,
    output logic [6:0]        HEX7
);

    localparam logic [4:0] FILL_L_LAST = 5'd17;
    localparam logic [4:0] FILL_R_LAST = 5'd18;
    localparam logic [4:0] BLINK_LAST  = 5'(2 * BLINK_REPS - 1);
    localparam logic [LEDR_W-1:0] LEDR_ONES = {LEDR_W{1'b1}};

    logic [2:0]        sw_meta_r;
    logic [2:0]        sw_sync_r;
    logic              pause_s;
    logic              step_en_s;
    state_t            state_r;
    state_t            state_nx_s;
    logic [4:0]        step_r;
    logic [4:0]        step_nx_s;
    logic [LEDR_W-1:0] ledr_s;
    logic [7:0]        ledg_s;
    logic [7:0][6:0]   hex_s;

    assign pause_s = sw_sync_r[0];

    // Two-flop synchronizer for the slide switches.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            sw_meta_r <= 3'b000;
            sw_sync_r <= 3'b000;
        end else begin
            sw_meta_r <= SW;
            sw_sync_r <= sw_meta_r;
        end
    end

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (CLOCK_50),
        .rst_n   (KEY0),
        .pause   (pause_s),
        .speed   (sw_sync_r[2:1]),
        .step_en (step_en_s)
    );

    // FSM state and step counter register.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_r <= FILL_L;
            step_r  <= 5'd0;
        end else begin
            state_r <= state_nx_s;
            step_r  <= step_nx_s;
        end
    end

    // Next state; an illegal encoding recovers to FILL_L without waiting for a step.
    always_comb begin
        state_nx_s = state_r;
        step_nx_s  = step_r;
        case (state_r)
            FILL_L: begin
                if (step_en_s && (step_r >= FILL_L_LAST)) begin
                    state_nx_s = FILL_R;
                    step_nx_s  = 5'd0;
                end else if (step_en_s) begin
                    step_nx_s = step_r + 5'd1;
                end else begin
                    step_nx_s = step_r;
                end
            end
            FILL_R: begin
                if (step_en_s && (step_r >= FILL_R_LAST)) begin
                    state_nx_s = BLINK;
                    step_nx_s  = 5'd0;
                end else if (step_en_s) begin
                    step_nx_s = step_r + 5'd1;
                end else begin
                    step_nx_s = step_r;
                end
            end
            BLINK: begin
                if (step_en_s && (step_r >= BLINK_LAST)) begin
                    state_nx_s = FILL_L;
                    step_nx_s  = 5'd0;
                end else if (step_en_s) begin
                    step_nx_s = step_r + 5'd1;
                end else begin
                    step_nx_s = step_r;
                end
            end
            default: begin
                state_nx_s = FILL_L;
                step_nx_s  = 5'd0;
            end
        endcase
    end

    // Display decode of the current state and step.
    always_comb begin
        ledr_s = {LEDR_W{1'b0}};
        ledg_s = 8'h00;
        hex_s  = {8{BLANK}};
        case (state_r)
            FILL_L: begin
                ledr_s    = ~(LEDR_ONES >> (step_r + 5'd1));
                ledg_s[0] = 1'b1;
            end
            FILL_R: begin
                ledr_s    = ~(LEDR_ONES << step_r);
                ledg_s[1] = 1'b1;
            end
            BLINK: begin
                ledg_s[2] = 1'b1;
                if (!step_r[0]) begin
                    hex_s = {GLYPH_H, GLYPH_A, GLYPH_P, GLYPH_P,
                             GLYPH_Y, GLYPH_D, GLYPH_A, GLYPH_Y};
                end else begin
                    hex_s = {8{BLANK}};
                end
            end
            default: begin
                ledg_s = 8'h00;
            end
        endcase
        ledg_s[7] = pause_s;
    end

    // Registered outputs, one cycle behind the state.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            LEDR <= {LEDR_W{1'b0}};
            LEDG <= 8'h00;
            HEX0 <= BLANK;
            HEX1 <= BLANK;
            HEX2 <= BLANK;
            HEX3 <= BLANK;
            HEX4 <= BLANK;
            HEX5 <= BLANK;
            HEX6 <= BLANK;
            HEX7 <= BLANK;
        end else begin
            LEDR <= ledr_s;
            LEDG <= ledg_s;
            HEX0 <= hex_s[0];
            HEX1 <= hex_s[1];
            HEX2 <= hex_s[2];
            HEX3 <= hex_s[3];
            HEX4 <= hex_s[4];
            HEX5 <= hex_s[5];
            HEX6 <= hex_s[6];
            HEX7 <= hex_s[7];
        end
    end

endmodule
